// File: rtl/tx_pkg.sv
// rtl/tx_pkg.sv - shared framing constants, state encoding and byte helpers for the tx/rx link
package tx_pkg;

    localparam logic [31:0] C_SFD         = 32'h5544557F;
    localparam logic [15:0] C_PACKET_TYPE = 16'h1234;
    localparam logic [7:0]  C_SIZE_MIN    = 8'h08;

    typedef enum logic [2:0] {
        COLLECT,
        SFD,
        TYPE,
        SIZE,
        PAYLOAD,
        FCS,
        GAP
    } state_t;

    // SFD byte i, most significant byte first
    function automatic logic [7:0] sfd_byte(input logic [1:0] i);
        logic [31:0] w;
        w = C_SFD << (8 * i);
        return w[31:24];
    endfunction

    // Running frame checksum: plain byte sum modulo 256
    function automatic logic [7:0] fcs_add(input logic [7:0] sum, input logic [7:0] b);
        return sum + b;
    endfunction

endpackage

// File: rtl/tx_buffer.sv
// rtl/tx_buffer.sv - store-and-forward payload RAM, one write port and one registered read port
module tx_buffer #(
    parameter int DEPTH = 255,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_in,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    // Write when enabled; read data appears one clock after the address
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/simple_tx.sv
// rtl/simple_tx.sv - collects one AXI-S packet and frames it onto the txd/txen/txer byte link
module simple_tx
    import tx_pkg::*;
#(
    parameter int G_MAX_PAYLOAD = 255,
    parameter int G_IFG         = 12
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [7:0]  tdata_in,
    input  logic        tvalid_in,
    input  logic        tlast_in,
    output logic        tready_out,
    input  logic        err_inject_in,
    output logic [7:0]  txd_out,
    output logic        txen_out,
    output logic        txer_out,
    output logic [15:0] stat_packet_sent_cnt,
    output logic [15:0] stat_packet_drop_cnt
);

    localparam int         AW        = $clog2(G_MAX_PAYLOAD);
    localparam logic [8:0] C_CNT_MAX = 9'(G_MAX_PAYLOAD);
    localparam logic [7:0] C_IFG_END = 8'(G_IFG);

    // The FSM runs one step ahead of the line: each step computes the byte that
    // the output registers present during the following cycle.
    state_t      state, state_nxt;
    logic [7:0]  idx, idx_nxt;
    logic [8:0]  cnt, cnt_nxt;
    logic [7:0]  sum, sum_nxt;
    logic        ovf, ovf_nxt;
    logic [7:0]  len, len_nxt;
    logic [7:0]  fcs, fcs_nxt;
    logic        err, err_nxt;
    logic [15:0] sent, sent_nxt;
    logic [15:0] drop, drop_nxt;
    logic [7:0]  txd_r, txd_nxt;
    logic        txen_r, txen_nxt;
    logic        txer_r, txer_nxt;
    logic        tready_r;
    logic        hs;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;

    assign hs = tvalid_in & tready_r;

    tx_buffer #(
        .DEPTH (G_MAX_PAYLOAD),
        .AW    (AW)
    ) u_buffer (
        .clk_in  (clk_in),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (tdata_in),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // State, counters and registered line outputs
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state    <= COLLECT;
            idx      <= '0;
            cnt      <= '0;
            sum      <= '0;
            ovf      <= 1'b0;
            len      <= '0;
            fcs      <= '0;
            err      <= 1'b0;
            sent     <= '0;
            drop     <= '0;
            txd_r    <= '0;
            txen_r   <= 1'b0;
            txer_r   <= 1'b0;
            tready_r <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            cnt      <= cnt_nxt;
            sum      <= sum_nxt;
            ovf      <= ovf_nxt;
            len      <= len_nxt;
            fcs      <= fcs_nxt;
            err      <= err_nxt;
            sent     <= sent_nxt;
            drop     <= drop_nxt;
            txd_r    <= txd_nxt;
            txen_r   <= txen_nxt;
            txer_r   <= txer_nxt;
            tready_r <= (state_nxt == COLLECT);
        end
    end

    // Next-state, buffer access and next line byte
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        sum_nxt   = sum;
        ovf_nxt   = ovf;
        len_nxt   = len;
        fcs_nxt   = fcs;
        err_nxt   = err;
        sent_nxt  = sent;
        drop_nxt  = drop;
        txd_nxt   = 8'h00;
        txen_nxt  = 1'b0;
        txer_nxt  = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = cnt[AW-1:0];
        rd_addr   = '0;

        case (state)
            COLLECT: begin
                if (hs) begin
                    if (cnt < C_CNT_MAX) begin
                        wr_en   = 1'b1;
                        cnt_nxt = cnt + 9'd1;
                    end else begin
                        ovf_nxt = 1'b1;
                    end
                    sum_nxt = fcs_add(sum, tdata_in);
                    if (tlast_in) begin
                        if (!ovf_nxt && cnt_nxt >= {1'b0, C_SIZE_MIN}) begin
                            len_nxt   = cnt_nxt[7:0];
                            fcs_nxt   = sum_nxt;
                            err_nxt   = err_inject_in;
                            state_nxt = SFD;
                            idx_nxt   = 8'd1;
                            txen_nxt  = 1'b1;
                            txd_nxt   = sfd_byte(2'd0);
                        end else begin
                            drop_nxt = drop + 16'd1;
                        end
                        cnt_nxt = '0;
                        sum_nxt = '0;
                        ovf_nxt = 1'b0;
                    end
                end
            end
            SFD: begin
                txen_nxt = 1'b1;
                txd_nxt  = sfd_byte(idx[1:0]);
                idx_nxt  = idx + 8'd1;
                if (idx == 8'd3) begin
                    state_nxt = TYPE;
                    idx_nxt   = '0;
                end
            end
            TYPE: begin
                txen_nxt = 1'b1;
                txd_nxt  = idx[0] ? C_PACKET_TYPE[7:0] : C_PACKET_TYPE[15:8];
                idx_nxt  = idx + 8'd1;
                if (idx[0]) begin
                    state_nxt = SIZE;
                    idx_nxt   = '0;
                end
            end
            SIZE: begin
                // buffer[0] is fetched here so PAYLOAD starts without a bubble
                txen_nxt  = 1'b1;
                txd_nxt   = len;
                rd_addr   = '0;
                state_nxt = PAYLOAD;
                idx_nxt   = '0;
            end
            PAYLOAD: begin
                txen_nxt = 1'b1;
                txd_nxt  = rd_data;
                if (idx == len - 8'd1) begin
                    state_nxt = FCS;
                    idx_nxt   = '0;
                end else begin
                    rd_addr = AW'(idx + 8'd1);
                    idx_nxt = idx + 8'd1;
                end
            end
            FCS: begin
                txen_nxt  = 1'b1;
                txd_nxt   = fcs;
                txer_nxt  = err;
                sent_nxt  = sent + 16'd1;
                state_nxt = GAP;
                idx_nxt   = '0;
            end
            GAP: begin
                // First GAP step is the FCS line cycle, then G_IFG idle line cycles
                idx_nxt = idx + 8'd1;
                if (idx == C_IFG_END) begin
                    state_nxt = COLLECT;
                    idx_nxt   = '0;
                end
            end
            default: begin
                state_nxt = COLLECT;
                idx_nxt   = '0;
            end
        endcase
    end

    assign tready_out           = tready_r;
    assign txd_out              = txd_r;
    assign txen_out             = txen_r;
    assign txer_out             = txer_r;
    assign stat_packet_sent_cnt = sent;
    assign stat_packet_drop_cnt = drop;

endmodule

// File: tb/tb_simple_tx.sv
// tb/tb_simple_tx.sv - scoreboard bench for simple_tx framing, drops, gap and reset
module tb_simple_tx;

    localparam int MAXP = 16;
    localparam int IFG  = 12;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic [7:0]  tdata_in = 8'h00;
    logic        tvalid_in = 1'b0;
    logic        tlast_in = 1'b0;
    logic        err_inject_in = 1'b0;
    logic        tready_out;
    logic [7:0]  txd_out;
    logic        txen_out;
    logic        txer_out;
    logic [15:0] stat_packet_sent_cnt;
    logic [15:0] stat_packet_drop_cnt;

    int total = 0;
    int bad   = 0;
    int run   = 0;
    logic [8:0] exp_q[$];
    int         len_q[$];
    logic [8:0] e;

    always #5 clk_in = ~clk_in;

    simple_tx #(
        .G_MAX_PAYLOAD (MAXP),
        .G_IFG         (IFG)
    ) dut (
        .clk_in               (clk_in),
        .rst_n_in             (rst_n_in),
        .tdata_in             (tdata_in),
        .tvalid_in            (tvalid_in),
        .tlast_in             (tlast_in),
        .tready_out           (tready_out),
        .err_inject_in        (err_inject_in),
        .txd_out              (txd_out),
        .txen_out             (txen_out),
        .txer_out             (txer_out),
        .stat_packet_sent_cnt (stat_packet_sent_cnt),
        .stat_packet_drop_cnt (stat_packet_drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Line monitor: pops expected {txer, txd} per txen cycle, checks frame length and idle zeros
    always @(negedge clk_in) begin
        if (!rst_n_in) begin
            run = 0;
        end else if (txen_out) begin
            run++;
            if (exp_q.size() == 0) begin
                check("unexp_txen", 32'(txen_out), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("line", 32'({txer_out, txd_out}), 32'(e));
            end
        end else begin
            check("idle_line", 32'({txer_out, txd_out}), 32'd0);
            if (run != 0) begin
                if (len_q.size() != 0) begin
                    check("frame_len", 32'(run), 32'(len_q.pop_front()));
                end else begin
                    check("frame_len_extra", 32'(run), 32'd0);
                end
                run = 0;
            end
        end
    end

    task automatic send_pkt(input int n, input logic [7:0] base, input logic err, input logic hold);
        logic [7:0] s;
        logic       ok;
        int         guard;
        s  = 8'h00;
        ok = (n >= 8) && (n <= MAXP);
        for (int i = 0; i < n; i++) begin
            s = s + base + 8'(i);
        end
        for (int i = 0; i < n; i++) begin
            tdata_in      = base + 8'(i);
            tvalid_in     = 1'b1;
            tlast_in      = (i == n - 1);
            err_inject_in = err;
            guard = 0;
            while (!tready_out && guard < 200) begin
                @(posedge clk_in);
                #1;
                guard++;
            end
            if (!tready_out) begin
                check("hs_timeout", 32'(tready_out), 32'd1);
            end
            if (i == n - 1 && ok) begin
                exp_q.push_back(9'h055);
                exp_q.push_back(9'h044);
                exp_q.push_back(9'h055);
                exp_q.push_back(9'h07F);
                exp_q.push_back(9'h012);
                exp_q.push_back(9'h034);
                exp_q.push_back({1'b0, 8'(n)});
                for (int k = 0; k < n; k++) begin
                    exp_q.push_back({1'b0, base + 8'(k)});
                end
                exp_q.push_back({err, s});
                len_q.push_back(n + 8);
            end
            @(posedge clk_in);
            #1;
            if (i < n - 1) begin
                check("rdy_mid", 32'(tready_out), 32'd1);
            end else begin
                check("rdy_end", 32'(tready_out), 32'(!ok));
                check("first_txen", 32'(txen_out), 32'(ok));
            end
        end
        if (!hold) begin
            tvalid_in = 1'b0;
            tlast_in  = 1'b0;
        end
        err_inject_in = 1'b0;
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || txen_out) && g < 400) begin
            @(posedge clk_in);
            #1;
            g++;
        end
        check("done_timeout", 32'(g < 400), 32'd1);
    endtask

    initial begin
        int c;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_txen", 32'(txen_out), 32'd0);
        check("rst_rdy", 32'(tready_out), 32'd0);
        check("rst_sent", 32'(stat_packet_sent_cnt), 32'd0);
        check("rst_drop", 32'(stat_packet_drop_cnt), 32'd0);
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;
        check("rdy_after_rst", 32'(tready_out), 32'd1);

        // 8-byte packet 01..08
        send_pkt(8, 8'h01, 1'b0, 1'b0);
        wait_done();
        check("sent_1", 32'(stat_packet_sent_cnt), 32'd1);

        // Short packet dropped
        send_pkt(5, 8'h10, 1'b0, 1'b0);
        repeat (5) @(posedge clk_in);
        #1;
        check("drop_short", 32'(stat_packet_drop_cnt), 32'd1);
        check("rdy_short", 32'(tready_out), 32'd1);

        // Oversize dropped, then exactly MAXP bytes sent
        send_pkt(20, 8'h30, 1'b0, 1'b0);
        check("drop_ovf", 32'(stat_packet_drop_cnt), 32'd2);
        send_pkt(16, 8'h60, 1'b0, 1'b0);
        wait_done();
        check("sent_max", 32'(stat_packet_sent_cnt), 32'd2);

        // Back-to-back with tvalid held: measure ready gap from the tlast handshake
        send_pkt(8, 8'h80, 1'b0, 1'b1);
        tlast_in = 1'b0;
        tdata_in = 8'h90;
        c = 0;
        while (!tready_out && c < 200) begin
            @(posedge clk_in);
            #1;
            c++;
        end
        check("gap_cycles", 32'(c), 32'(8 + 8 + IFG));
        send_pkt(8, 8'h90, 1'b0, 1'b0);
        wait_done();
        check("sent_b2b", 32'(stat_packet_sent_cnt), 32'd4);

        // Error injection on FCS, checksum wraps
        send_pkt(9, 8'hF0, 1'b1, 1'b0);
        wait_done();
        check("sent_err", 32'(stat_packet_sent_cnt), 32'd5);

        // Reset during the third payload byte
        send_pkt(12, 8'hA0, 1'b0, 1'b0);
        repeat (9) @(posedge clk_in);
        #1;
        check("pre_rst_txd", 32'(txd_out), 32'hA2);
        #1;
        rst_n_in = 1'b0;
        #1;
        check("mid_rst_txen", 32'(txen_out), 32'd0);
        check("mid_rst_txd", 32'(txd_out), 32'd0);
        check("mid_rst_sent", 32'(stat_packet_sent_cnt), 32'd0);
        check("mid_rst_drop", 32'(stat_packet_drop_cnt), 32'd0);
        check("mid_rst_rdy", 32'(tready_out), 32'd0);
        exp_q.delete();
        len_q.delete();
        repeat (2) @(posedge clk_in);
        #3;
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;
        check("rdy_after_mid_rst", 32'(tready_out), 32'd1);
        send_pkt(8, 8'hC0, 1'b0, 1'b0);
        wait_done();
        repeat (3) @(posedge clk_in);
        #1;
        check("sent_after_rst", 32'(stat_packet_sent_cnt), 32'd1);
        check("drop_after_rst", 32'(stat_packet_drop_cnt), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("len_queue_empty", 32'(len_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
